sevenseg_scan_n: RTL and testbench

- Parametrised N-digit multiplexed seven-segment driver. Successor to the fixed 4-digit scanner.
- Adds configurable digit count, explicit dead-time between digits, hex or decimal glyphs, per-digit decimal points, and leading-zero blanking.
- Adds a valid/ready update handshake; new values are applied only at frame boundaries, so a frame never shows mixed data.
- Sits between the counter/datapath logic and the board's common-anode display pins.

---
 rtl/sevenseg_pkg.sv | 39 +++
 rtl/sevenseg_glyph.sv | 36 +++
 rtl/sevenseg_scan_n.sv | 169 ++++++++++++++++
 tb/tb_sevenseg_scan_n.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - glyph constants, scan state enum and width helper for sevenseg_scan_n
package sevenseg_pkg;

    // Segment patterns, {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_A    = 7'h08;
    localparam logic [6:0] SEG_B    = 7'h03;
    localparam logic [6:0] SEG_C    = 7'h46;
    localparam logic [6:0] SEG_D    = 7'h21;
    localparam logic [6:0] SEG_E    = 7'h06;
    localparam logic [6:0] SEG_F    = 7'h0E;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    // Bits needed to count 0..value-1
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sevenseg_glyph.sv
// rtl/sevenseg_glyph.sv - combinational nibble to seven-segment glyph decoder
module sevenseg_glyph
    import sevenseg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [6:0] seg
);

    // Decode the nibble; 10..15 show letters in hex mode, a dash otherwise
    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            case (value)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = hex_mode ? SEG_A : SEG_DASH;
                4'hB: seg = hex_mode ? SEG_B : SEG_DASH;
                4'hC: seg = hex_mode ? SEG_C : SEG_DASH;
                4'hD: seg = hex_mode ? SEG_D : SEG_DASH;
                4'hE: seg = hex_mode ? SEG_E : SEG_DASH;
                4'hF: seg = hex_mode ? SEG_F : SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/sevenseg_scan_n.sv
// rtl/sevenseg_scan_n.sv - N-digit multiplexed seven-segment scanner with frame-aligned updates (option: SEVENSEG_DIM_EN)
module sevenseg_scan_n
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int ON_CYC     = 50000,
    parameter int DEAD_CYC   = 500,
    parameter int HEX_MODE   = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    upd_valid,
    input  logic [4*NUM_DIGITS-1:0] upd_data,
    input  logic [NUM_DIGITS-1:0]   upd_dp,
    output logic                    upd_ready,
    output logic                    upd_ack,
    input  logic                    lzb_en,
`ifdef SEVENSEG_DIM_EN
    input  logic [3:0]              brightness,
`endif
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam int CNT_W = clog2(((ON_CYC > DEAD_CYC) ? ON_CYC : DEAD_CYC) + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic             HEX_BIT   = (HEX_MODE != 0);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [CNT_W-1:0]        cnt;
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [4*NUM_DIGITS-1:0] stage_data;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   stage_dp;
    logic                    pending;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [NUM_DIGITS-1:0]   sel_onehot;
    logic [3:0]              cur_val;
    logic [6:0]              glyph_seg;
    logic                    frame_end;
    logic                    drive_en;

    // Last cycle of the last digit's slot: the only point where the display may change
    always_comb begin
        frame_end = (state == S_DRIVE) && (cnt == ON_LAST) && (idx == LAST_IDX);
    end

    // A digit is blanked when it and every digit above it are zero; digit 0 always shows
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run && (disp_data[4*i +: 4] == 4'h0);
            blank_vec[i] = lzb_en && zero_run;
        end
    end

    // Select the nibble and anode for the digit currently being scanned
    always_comb begin
        cur_val    = disp_data[{idx, 2'b00} +: 4];
        sel_onehot = NUM_DIGITS'(1) << idx;
    end

    sevenseg_glyph u_glyph (
        .value    (cur_val),
        .hex_mode (HEX_BIT),
        .blank    (blank_vec[idx]),
        .seg      (glyph_seg)
    );

`ifdef SEVENSEG_DIM_EN
    logic [3:0] pwm_cnt;

    // Free-running duty counter; it is not synchronised to slots on purpose
    always_ff @(posedge clock) begin
        if (!reset) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    // Full scale keeps the anode on permanently rather than 15/16
    always_comb begin
        drive_en = (brightness == 4'hF) || (pwm_cnt < brightness);
    end
`else
    // Without dimming the selected anode is driven for the whole slot
    always_comb begin
        drive_en = 1'b1;
    end
`endif

    // Scan FSM: dead time then drive per digit; outputs registered from the current state
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_BLANK;
            idx   <= '0;
            cnt   <= '0;
            an    <= '1;
            seg   <= SEG_OFF;
            dp    <= 1'b1;
        end else begin
            if (state == S_DRIVE) begin
                an  <= drive_en ? ~sel_onehot : '1;
                seg <= glyph_seg;
                dp  <= ~disp_dp[idx];
            end else begin
                an  <= '1;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
            case (state)
                S_BLANK: begin
                    if (cnt == DEAD_LAST) begin
                        cnt   <= '0;
                        state <= S_DRIVE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (cnt == ON_LAST) begin
                        cnt   <= '0;
                        state <= S_BLANK;
                        idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_BLANK;
            endcase
        end
    end

    // Update handshake: one staging slot, committed to the display only at frame end
    always_ff @(posedge clock) begin
        if (!reset) begin
            stage_data <= '0;
            stage_dp   <= '0;
            disp_data  <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
            upd_ready  <= 1'b1;
            upd_ack    <= 1'b0;
        end else begin
            upd_ack <= 1'b0;
            if (frame_end && pending) begin
                disp_data <= stage_data;
                disp_dp   <= stage_dp;
                pending   <= 1'b0;
                upd_ready <= 1'b1;
                upd_ack   <= 1'b1;
            end else if (upd_valid && upd_ready) begin
                stage_data <= upd_data;
                stage_dp   <= upd_dp;
                pending    <= 1'b1;
                upd_ready  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_n.sv
// tb/tb_sevenseg_scan_n.sv - scoreboard bench for sevenseg_scan_n (4 digits, ON 8, DEAD 2)
`timescale 1ns/1ps
module tb_sevenseg_scan_n;

    localparam int ND    = 4;
    localparam int ON    = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = ND * (ON + DEAD);
    localparam int LOGSZ = 16384;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_data = 16'h0;
    logic [3:0]  upd_dp = 4'h0;
    logic        lzb_en = 1'b0;
    logic        upd_ready, upd_ack, dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        upd_ready_h, upd_ack_h, dp_h;
    logic [3:0]  an_h;
    logic [6:0]  seg_h;
`ifdef SEVENSEG_DIM_EN
    logic [3:0]  brightness = 4'hF;
`endif

    always #5 clock = ~clock;

    sevenseg_scan_n #(.NUM_DIGITS(ND), .ON_CYC(ON), .DEAD_CYC(DEAD), .HEX_MODE(0)) dut (
        .clock(clock), .reset(reset), .upd_valid(upd_valid), .upd_data(upd_data),
        .upd_dp(upd_dp), .upd_ready(upd_ready), .upd_ack(upd_ack), .lzb_en(lzb_en),
`ifdef SEVENSEG_DIM_EN
        .brightness(brightness),
`endif
        .an(an), .seg(seg), .dp(dp)
    );

    sevenseg_scan_n #(.NUM_DIGITS(ND), .ON_CYC(ON), .DEAD_CYC(DEAD), .HEX_MODE(1)) dut_hex (
        .clock(clock), .reset(reset), .upd_valid(upd_valid), .upd_data(upd_data),
        .upd_dp(upd_dp), .upd_ready(upd_ready_h), .upd_ack(upd_ack_h), .lzb_en(lzb_en),
`ifdef SEVENSEG_DIM_EN
        .brightness(brightness),
`endif
        .an(an_h), .seg(seg_h), .dp(dp_h)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [3:0] an_log   [LOGSZ];
    logic [6:0] seg_log  [LOGSZ];
    logic [6:0] segh_log [LOGSZ];
    logic       dp_log   [LOGSZ];

    always @(negedge clock) begin
        if (cyc < LOGSZ) begin
            an_log[cyc]   = an;
            seg_log[cyc]  = seg;
            segh_log[cyc] = seg_h;
            dp_log[cyc]   = dp;
        end
        cyc = cyc + 1;
    end

    typedef struct {
        int         at;
        logic       hexdut;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   last_at = 0;

    function automatic logic [6:0] ref_glyph(input logic [3:0] v, input logic hex);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return hex ? 7'b0001000 : 7'b0111111;
            4'hB: return hex ? 7'b0000011 : 7'b0111111;
            4'hC: return hex ? 7'b1000110 : 7'b0111111;
            4'hD: return hex ? 7'b0100001 : 7'b0111111;
            4'hE: return hex ? 7'b0000110 : 7'b0111111;
            default: return hex ? 7'b0001110 : 7'b0111111;
        endcase
    endfunction

    // Expected per-cycle outputs for one frame whose first driven cycle is at index base
    function automatic void push_frame(input int base, input logic [15:0] data,
                                       input logic [3:0] dps, input logic lzb, input logic hexdut);
        int         k;
        logic       zr;
        logic [3:0] blank;
        logic [3:0] oh;
        exp_t       e;
        k     = base;
        zr    = 1'b1;
        blank = 4'b0000;
        for (int i = 3; i >= 1; i--) begin
            zr       = zr && (data[4*i +: 4] == 4'h0);
            blank[i] = lzb && zr;
        end
        for (int d = 0; d < ND; d++) begin
            oh = 4'b0001 << d;
            for (int c = 0; c < ON; c++) begin
                e.at = k; e.hexdut = hexdut; e.an = ~oh;
                e.seg = blank[d] ? 7'h7F : ref_glyph(data[4*d +: 4], hexdut);
                e.dp = ~dps[d];
                exp_q.push_back(e);
                k++;
            end
            for (int c = 0; c < DEAD; c++) begin
                e.at = k; e.hexdut = hexdut; e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
                exp_q.push_back(e);
                k++;
            end
        end
        if (k - 1 > last_at) last_at = k - 1;
    endfunction

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic wait_cover;
        int guard = 0;
        while (cyc <= last_at && guard < 1000) begin
            tick;
            guard++;
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] p, output int acc);
        int guard = 0;
        upd_valid = 1'b1;
        upd_data  = d;
        upd_dp    = p;
        acc       = -1;
        while (guard < 200) begin
            if (upd_ready) begin
                acc = cyc;
                tick;
                break;
            end
            tick;
            guard++;
        end
        upd_valid = 1'b0;
    endtask

    task automatic wait_ack(output int at);
        int guard = 0;
        at = -1;
        while (guard < 200) begin
            if (upd_ack) begin
                at = cyc;
                break;
            end
            tick;
            guard++;
        end
    endtask

    task automatic test_reset;
        int   n;
        exp_t e;
        logic [6:0] s;
        reset = 1'b0;
        repeat (3) tick;
        total++; if (an !== 4'b1111) $display("FAIL reset_an got %b want 1111", an); else passed++;
        total++; if (seg !== 7'h7F) $display("FAIL reset_seg got %h want 7f", seg); else passed++;
        total++; if (dp !== 1'b1) $display("FAIL reset_dp got %b want 1", dp); else passed++;
        total++; if (upd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", upd_ready); else passed++;
        total++; if (upd_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", upd_ack); else passed++;
        reset = 1'b1;
        n = 0;
        while (an !== 4'b1110 && n < 20) begin
            tick;
            n++;
        end
        total++; if (n !== 3) $display("FAIL reset_latency got %0d want 3", n); else passed++;
        push_frame(cyc, 16'h0000, 4'h0, 1'b0, 1'b0);
        wait_cover;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); s = e.hexdut ? segh_log[e.at] : seg_log[e.at]; total++;
            if ({an_log[e.at], s, dp_log[e.at]} !== {e.an, e.seg, e.dp})
                $display("FAIL reset_frame cyc %0d got an/seg/dp %b/%b/%b want %b/%b/%b", e.at, an_log[e.at], s, dp_log[e.at], e.an, e.seg, e.dp);
            else passed++;
        end
    endtask

    task automatic test_scan;
        int acc, a;
        exp_t e;
        logic [6:0] s;
        lzb_en = 1'b0;
        send(16'h1234, 4'b0101, acc);
        wait_ack(a);
        total++;
        if (acc < 0 || a < 0) $display("FAIL scan_handshake got acc %0d ack %0d want both >= 0", acc, a);
        else begin
            passed++;
            push_frame(a + 3, 16'h1234, 4'b0101, 1'b0, 1'b0);
        end
        tick;
        total++; if (upd_ack !== 1'b0) $display("FAIL scan_ack_width got %b want 0", upd_ack); else passed++;
        total++; if (upd_ready !== 1'b1) $display("FAIL scan_ready_back got %b want 1", upd_ready); else passed++;
        wait_cover;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); s = e.hexdut ? segh_log[e.at] : seg_log[e.at]; total++;
            if ({an_log[e.at], s, dp_log[e.at]} !== {e.an, e.seg, e.dp})
                $display("FAIL scan_frame cyc %0d got an/seg/dp %b/%b/%b want %b/%b/%b", e.at, an_log[e.at], s, dp_log[e.at], e.an, e.seg, e.dp);
            else passed++;
        end
    endtask

    task automatic test_lzb;
        int acc, a1, a2;
        exp_t e;
        logic [6:0] s;
        lzb_en = 1'b1;
        send(16'h0042, 4'b1000, acc);
        wait_ack(a1);
        send(16'h0000, 4'b0000, acc);
        wait_ack(a2);
        total++;
        if (a1 < 0 || a2 < 0) $display("FAIL lzb_handshake got ack %0d/%0d want both >= 0", a1, a2);
        else begin
            passed++;
            push_frame(a1 + 3, 16'h0042, 4'b1000, 1'b1, 1'b0);
            push_frame(a2 + 3, 16'h0000, 4'b0000, 1'b1, 1'b0);
        end
        wait_cover;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); s = e.hexdut ? segh_log[e.at] : seg_log[e.at]; total++;
            if ({an_log[e.at], s, dp_log[e.at]} !== {e.an, e.seg, e.dp})
                $display("FAIL lzb_frame cyc %0d got an/seg/dp %b/%b/%b want %b/%b/%b", e.at, an_log[e.at], s, dp_log[e.at], e.an, e.seg, e.dp);
            else passed++;
        end
        lzb_en = 1'b0;
    endtask

    task automatic test_hex;
        int acc, a;
        exp_t e;
        logic [6:0] s;
        send(16'hABCD, 4'b0000, acc);
        wait_ack(a);
        total++;
        if (a < 0) $display("FAIL hex_handshake got ack %0d want >= 0", a);
        else begin
            passed++;
            push_frame(a + 3, 16'hABCD, 4'b0000, 1'b0, 1'b0);
            push_frame(a + 3, 16'hABCD, 4'b0000, 1'b0, 1'b1);
        end
        wait_cover;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); s = e.hexdut ? segh_log[e.at] : seg_log[e.at]; total++;
            if ({an_log[e.at], s, dp_log[e.at]} !== {e.an, e.seg, e.dp})
                $display("FAIL hex_frame hexdut %0d cyc %0d got an/seg/dp %b/%b/%b want %b/%b/%b", e.hexdut, e.at, an_log[e.at], s, dp_log[e.at], e.an, e.seg, e.dp);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        int acc_a, ack_a, acc_b, ack_b, guard;
        exp_t e;
        logic [6:0] s;
        repeat (10) tick;
        send(16'h5678, 4'b0011, acc_a);
        total++; if (upd_ready !== 1'b0) $display("FAIL b2b_ready_drop got %b want 0", upd_ready); else passed++;
        upd_valid = 1'b1;
        upd_data  = 16'h9012;
        upd_dp    = 4'b1100;
        ack_a = -1;
        acc_b = -1;
        guard = 0;
        while (guard < 200) begin
            if (upd_ack && ack_a < 0) ack_a = cyc;
            if (upd_ready) begin
                acc_b = cyc;
                tick;
                break;
            end
            tick;
            guard++;
        end
        upd_valid = 1'b0;
        total++;
        if (ack_a < 0 || acc_b !== ack_a) $display("FAIL b2b_accept_b got accept %0d want ack cycle %0d", acc_b, ack_a);
        else passed++;
        wait_ack(ack_b);
        total++;
        if (ack_a < 0 || ack_b !== ack_a + FRAME) $display("FAIL b2b_ack_spacing got %0d want %0d", ack_b, ack_a + FRAME);
        else passed++;
        if (ack_a >= 0 && ack_b >= 0) begin
            push_frame(ack_a + 3, 16'h5678, 4'b0011, 1'b0, 1'b0);
            push_frame(ack_b + 3, 16'h9012, 4'b1100, 1'b0, 1'b0);
        end
        wait_cover;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); s = e.hexdut ? segh_log[e.at] : seg_log[e.at]; total++;
            if ({an_log[e.at], s, dp_log[e.at]} !== {e.an, e.seg, e.dp})
                $display("FAIL b2b_frame cyc %0d got an/seg/dp %b/%b/%b want %b/%b/%b", e.at, an_log[e.at], s, dp_log[e.at], e.an, e.seg, e.dp);
            else passed++;
        end
    endtask

    task automatic test_reset_mid;
        int acc, n, guard;
        logic saw_ack;
        exp_t e;
        logic [6:0] s;
        send(16'h7777, 4'b1111, acc);
        repeat (3) tick;
        reset = 1'b0;
        repeat (2) tick;
        total++; if (upd_ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", upd_ready); else passed++;
        total++; if (an !== 4'b1111) $display("FAIL rmid_an got %b want 1111", an); else passed++;
        reset = 1'b1;
        n = 0;
        while (an !== 4'b1110 && n < 20) begin
            tick;
            n++;
        end
        total++; if (n !== 3) $display("FAIL rmid_latency got %0d want 3", n); else passed++;
        push_frame(cyc, 16'h0000, 4'h0, 1'b0, 1'b0);
        saw_ack = 1'b0;
        guard = 0;
        while ((cyc <= last_at || guard < 60) && guard < 1000) begin
            if (upd_ack) saw_ack = 1'b1;
            tick;
            guard++;
        end
        total++; if (saw_ack !== 1'b0) $display("FAIL rmid_no_ack got %b want 0", saw_ack); else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); s = e.hexdut ? segh_log[e.at] : seg_log[e.at]; total++;
            if ({an_log[e.at], s, dp_log[e.at]} !== {e.an, e.seg, e.dp})
                $display("FAIL rmid_frame cyc %0d got an/seg/dp %b/%b/%b want %b/%b/%b", e.at, an_log[e.at], s, dp_log[e.at], e.an, e.seg, e.dp);
            else passed++;
        end
    endtask

`ifdef SEVENSEG_DIM_EN
    task automatic test_dim;
        int acc, a, lit, run, max_run;
        brightness = 4'd0;
        lit = 0;
        send(16'h1111, 4'b0000, acc);
        wait_ack(a);
        total++; if (a < 0) $display("FAIL dim_ack_dark got %0d want >= 0", a); else passed++;
        repeat (80) begin
            if (an !== 4'hF) lit++;
            tick;
        end
        total++; if (lit !== 0) $display("FAIL dim_dark got %0d lit cycles want 0", lit); else passed++;
        brightness = 4'd4;
        lit = 0; run = 0; max_run = 0;
        repeat (160) begin
            if (an !== 4'hF) begin
                lit++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            tick;
        end
        total++; if (lit == 0) $display("FAIL dim_some_lit got %0d want > 0", lit); else passed++;
        total++; if (max_run > 4) $display("FAIL dim_run got %0d want <= 4", max_run); else passed++;
        brightness = 4'hF;
    endtask
`endif

    initial begin
        test_reset;
        test_scan;
        test_lzb;
        test_hex;
        test_back_to_back;
        test_reset_mid;
`ifdef SEVENSEG_DIM_EN
        test_dim;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
